trigger_sched: RTL and testbench

- Sequences trigger pulses for the trigger-mode acquisition path.
- Sits between the delayed trigger (output of trigger_delay) and trigger_extend, at the input that feeds o_trigger_n.
- One accepted request expands into a burst of N sensor triggers. Each trigger waits for the previous frame (fval) to finish, then for a programmable holdoff.
- Requests that arrive while a burst is in progress are dropped and counted.

---
 rtl/io_channel_pkg.sv | 28 ++
 rtl/fval_sync_edge.sv | 31 +++
 rtl/trigger_sched.sv | 169 ++++++++++++++++
 tb/tb_trigger_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_channel_pkg.sv
// Shared definitions for the trigger-mode acquisition path: scheduler state
// encoding, default widths and a busy-state helper.
package io_channel_pkg;

    localparam int BURST_WIDTH_DEF    = 8;
    localparam int HOLDOFF_WIDTH_DEF  = 24;
    localparam int TIMEOUT_WIDTH_DEF  = 26;
    localparam int MISS_CNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_HOLDOFF   = 3'd5
    } sched_state_e;

    function automatic logic state_is_busy(input sched_state_e st);
        logic busy;
        case (st)
            ST_FIRE, ST_WAIT_RISE, ST_WAIT_FALL, ST_HOLDOFF: busy = 1'b1;
            default:                                        busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/fval_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a third flop that turns
// the synchronised level into one-clock rise and fall pulses.
module fval_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchroniser chain and edge-detect history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/trigger_sched.sv
// Expands each accepted trigger request into a burst of sensor trigger pulses,
// pacing them on frame-valid completion plus a programmable holdoff.
module trigger_sched
    import io_channel_pkg::*;
#(
    parameter int BURST_WIDTH    = BURST_WIDTH_DEF,
    parameter int HOLDOFF_WIDTH  = HOLDOFF_WIDTH_DEF,
    parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF,
    parameter int MISS_CNT_WIDTH = MISS_CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_trigger_mode,
    input  logic                      i_acquisition_start,
    input  logic                      i_stream_enable,
    input  logic                      i_trig_req,
    input  logic [BURST_WIDTH-1:0]    iv_burst_count,
    input  logic [HOLDOFF_WIDTH-1:0]  iv_frame_holdoff,
    input  logic [TIMEOUT_WIDTH-1:0]  iv_fval_timeout,
    input  logic                      i_fval,
    output logic                      o_trig_pulse,
    output logic                      o_busy,
    output logic                      o_timeout,
    output logic [MISS_CNT_WIDTH-1:0] ov_missed_cnt,
    output logic [BURST_WIDTH-1:0]    ov_burst_remain
);

    sched_state_e              r_state;
    logic                      r_enable;
    logic                      r_enable_d;
    logic                      r_req;
    logic                      r_req_d;
    logic [BURST_WIDTH-1:0]    r_remain;
    logic [HOLDOFF_WIDTH-1:0]  r_holdoff_cfg;
    logic [HOLDOFF_WIDTH-1:0]  r_hold_cnt;
    logic [TIMEOUT_WIDTH-1:0]  r_timeout_cfg;
    logic [TIMEOUT_WIDTH-1:0]  r_wd_cnt;
    logic                      r_trig_pulse;
    logic                      r_busy;
    logic                      r_timeout;
    logic [MISS_CNT_WIDTH-1:0] r_missed;

    logic                      w_fval_rise;
    logic                      w_fval_fall;
    logic                      w_req;
    logic                      w_en_rise;
    logic [BURST_WIDTH-1:0]    w_burst_eff;
    logic [TIMEOUT_WIDTH-1:0]  w_wd_next;

    fval_sync_edge u_fval_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (i_fval),
        .o_rise  (w_fval_rise),
        .o_fall  (w_fval_fall)
    );

    assign w_req       = r_req & ~r_req_d;
    assign w_en_rise   = r_enable & ~r_enable_d;
    assign w_burst_eff = (iv_burst_count == '0) ? BURST_WIDTH'(1) : iv_burst_count;
    assign w_wd_next   = r_wd_cnt + TIMEOUT_WIDTH'(1);

    // Scheduler FSM with input registering, status flags and missed-request count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_enable      <= 1'b0;
            r_enable_d    <= 1'b0;
            r_req         <= 1'b0;
            r_req_d       <= 1'b0;
            r_remain      <= '0;
            r_holdoff_cfg <= '0;
            r_hold_cnt    <= '0;
            r_timeout_cfg <= '0;
            r_wd_cnt      <= '0;
            r_trig_pulse  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
            r_missed      <= '0;
        end else begin
            r_enable     <= i_trigger_mode & i_acquisition_start & i_stream_enable;
            r_enable_d   <= r_enable;
            r_req        <= i_trig_req;
            r_req_d      <= r_req;
            r_trig_pulse <= 1'b0;

            // A fresh enable starts a clean session; otherwise busy-time requests are lost
            if (w_en_rise) begin
                r_timeout <= 1'b0;
                r_missed  <= '0;
            end else if (w_req && r_enable && state_is_busy(r_state) && (r_missed != '1)) begin
                r_missed <= r_missed + MISS_CNT_WIDTH'(1);
            end else begin
                r_missed <= r_missed;
            end

            if (!r_enable) begin
                r_state  <= ST_IDLE;
                r_remain <= '0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARMED;
                        r_busy  <= 1'b0;
                    end
                    ST_ARMED: begin
                        if (w_req) begin
                            r_remain      <= w_burst_eff;
                            r_holdoff_cfg <= iv_frame_holdoff;
                            r_timeout_cfg <= iv_fval_timeout;
                            r_state       <= ST_FIRE;
                            r_busy        <= 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        r_trig_pulse <= 1'b1;
                        r_remain     <= r_remain - BURST_WIDTH'(1);
                        r_wd_cnt     <= '0;
                        r_state      <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        // A frame start seen in the expiry cycle still counts as a frame
                        if (w_fval_rise) begin
                            r_state <= ST_WAIT_FALL;
                        end else if ((r_timeout_cfg != '0) && (w_wd_next == r_timeout_cfg)) begin
                            r_timeout <= 1'b1;
                            r_remain  <= '0;
                            r_state   <= ST_ARMED;
                            r_busy    <= 1'b0;
                        end else begin
                            r_wd_cnt <= w_wd_next;
                        end
                    end
                    ST_WAIT_FALL: begin
                        if (w_fval_fall) begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLDOFF;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_hold_cnt == r_holdoff_cfg) begin
                            if (r_remain != '0) begin
                                r_state <= ST_FIRE;
                            end else begin
                                r_state <= ST_ARMED;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLDOFF_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_remain <= '0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_trig_pulse    = r_trig_pulse;
    assign o_busy          = r_busy;
    assign o_timeout       = r_timeout;
    assign ov_missed_cnt   = r_missed;
    assign ov_burst_remain = r_remain;

endmodule

// File: tb/tb_trigger_sched.sv
// Scoreboard bench for trigger_sched: stimulus queues expected pulse cycles and
// status values, a monitor compares them when the DUT presents them.
module tb_trigger_sched;

    localparam int BW = 8;
    localparam int HW = 24;
    localparam int TW = 26;
    localparam int MW = 4;
    localparam int CYC_LIMIT = 5000;

    localparam int S_BUSY    = 0;
    localparam int S_REMAIN  = 1;
    localparam int S_TIMEOUT = 2;
    localparam int S_MISSED  = 3;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } chk_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_trigger_mode;
    logic          i_acquisition_start;
    logic          i_stream_enable;
    logic          i_trig_req;
    logic [BW-1:0] iv_burst_count;
    logic [HW-1:0] iv_frame_holdoff;
    logic [TW-1:0] iv_fval_timeout;
    logic          i_fval;
    logic          o_trig_pulse;
    logic          o_busy;
    logic          o_timeout;
    logic [MW-1:0] ov_missed_cnt;
    logic [BW-1:0] ov_burst_remain;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic fval_auto = 1'b1;
    logic done = 1'b0;
    chk_t chk_q[$];
    int   pulse_q[$];

    trigger_sched #(
        .BURST_WIDTH    (BW),
        .HOLDOFF_WIDTH  (HW),
        .TIMEOUT_WIDTH  (TW),
        .MISS_CNT_WIDTH (MW)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_trigger_mode      (i_trigger_mode),
        .i_acquisition_start (i_acquisition_start),
        .i_stream_enable     (i_stream_enable),
        .i_trig_req          (i_trig_req),
        .iv_burst_count      (iv_burst_count),
        .iv_frame_holdoff    (iv_frame_holdoff),
        .iv_fval_timeout     (iv_fval_timeout),
        .i_fval              (i_fval),
        .o_trig_pulse        (o_trig_pulse),
        .o_busy              (o_busy),
        .o_timeout           (o_timeout),
        .ov_missed_cnt       (ov_missed_cnt),
        .ov_burst_remain     (ov_burst_remain)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            S_BUSY:    return "busy";
            S_REMAIN:  return "remain";
            S_TIMEOUT: return "timeout";
            S_MISSED:  return "missed";
            default:   return "unknown";
        endcase
    endfunction

    function int actual(input int s);
        case (s)
            S_BUSY:    return int'(o_busy);
            S_REMAIN:  return int'(ov_burst_remain);
            S_TIMEOUT: return int'(o_timeout);
            S_MISSED:  return int'(ov_missed_cnt);
            default:   return -1;
        endcase
    endfunction

    task automatic run_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_at(input int k, input int s, input int v);
        chk_t c;
        c.cyc = k;
        c.sig = s;
        c.val = v;
        chk_q.push_back(c);
    endtask

    task automatic request(input int k);
        run_to(k);
        i_trig_req = 1'b1;
        run_to(k + 1);
        i_trig_req = 1'b0;
    endtask

    // Sensor model: frame valid rises 50 cycles after a pulse and lasts 20 cycles
    initial begin : fval_model
        i_fval = 1'b0;
        forever begin
            @(negedge clk);
            if (o_trig_pulse && fval_auto) begin
                repeat (50) @(posedge clk);
                #2 i_fval = 1'b1;
                repeat (20) @(posedge clk);
                #2 i_fval = 1'b0;
            end
        end
    end

    initial begin : monitor
        chk_t keep[$];
        int   act;
        int   exp_cyc;
        forever begin
            @(negedge clk);
            if (o_trig_pulse) begin
                n_cmp++;
                if (pulse_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    exp_cyc = pulse_q.pop_front();
                    if (exp_cyc != cyc) begin
                        n_fail++;
                        $display("FAIL pulse_cycle: got pulse at cycle %0d, want cycle %0d", cyc, exp_cyc);
                    end
                end
            end
            keep = {};
            foreach (chk_q[i]) begin
                if (chk_q[i].cyc == cyc) begin
                    act = actual(chk_q[i].sig);
                    n_cmp++;
                    if (act != chk_q[i].val) begin
                        n_fail++;
                        $display("FAIL %s@%0d: got %0d, want %0d", sig_name(chk_q[i].sig), cyc, act, chk_q[i].val);
                    end
                end else begin
                    keep.push_back(chk_q[i]);
                end
            end
            chk_q = keep;
            if (done || (cyc > CYC_LIMIT)) begin
                if (!done) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL run_timeout: got cycle %0d, want stimulus done by %0d", cyc, CYC_LIMIT);
                end
                n_cmp++;
                if (pulse_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL pulses_missing: got %0d outstanding, want 0", pulse_q.size());
                end
                n_cmp++;
                if (chk_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL checks_unvisited: got %0d outstanding, want 0", chk_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    end

    initial begin : stimulus
        reset_n             = 1'b0;
        i_trigger_mode      = 1'b1;
        i_acquisition_start = 1'b1;
        i_stream_enable     = 1'b1;
        i_trig_req          = 1'b0;
        iv_burst_count      = 8'd3;
        iv_frame_holdoff    = 24'd10;
        iv_fval_timeout     = 26'd0;

        // Reset state
        run_to(3);
        for (int s = 0; s < 4; s++) expect_at(4, s, 0);
        run_to(4);
        reset_n = 1'b1;

        // Burst of 3, holdoff 10: pulses 85 cycles apart
        run_to(10);
        pulse_q.push_back(13);
        pulse_q.push_back(98);
        pulse_q.push_back(183);
        expect_at(11, S_BUSY, 0);
        expect_at(12, S_BUSY, 1);
        expect_at(13, S_REMAIN, 2);
        expect_at(98, S_REMAIN, 1);
        expect_at(183, S_REMAIN, 0);
        expect_at(266, S_BUSY, 1);
        expect_at(267, S_BUSY, 0);
        expect_at(267, S_MISSED, 0);
        request(10);
        run_to(275);

        // Burst count 0 behaves as 1
        iv_burst_count = 8'd0;
        pulse_q.push_back(283);
        expect_at(282, S_REMAIN, 1);
        expect_at(283, S_REMAIN, 0);
        expect_at(367, S_BUSY, 0);
        request(280);
        run_to(375);

        // Requests during a burst are counted, saturating at all-ones
        iv_burst_count = 8'd1;
        pulse_q.push_back(383);
        expect_at(401, S_MISSED, 5);
        expect_at(420, S_MISSED, 14);
        expect_at(430, S_MISSED, 15);
        expect_at(430, S_BUSY, 1);
        expect_at(430, S_REMAIN, 0);
        request(380);
        for (int k = 0; k < 5; k++) request(390 + 2 * k);
        for (int k = 0; k < 12; k++) request(402 + 2 * k);
        run_to(475);

        // Watchdog: no frame after the pulse
        fval_auto       = 1'b0;
        iv_burst_count  = 8'd3;
        iv_fval_timeout = 26'd100;
        pulse_q.push_back(483);
        expect_at(582, S_TIMEOUT, 0);
        expect_at(582, S_REMAIN, 2);
        expect_at(583, S_TIMEOUT, 1);
        expect_at(583, S_REMAIN, 0);
        expect_at(583, S_BUSY, 0);
        request(480);
        run_to(590);
        fval_auto      = 1'b1;
        iv_burst_count = 8'd1;
        pulse_q.push_back(593);
        expect_at(677, S_BUSY, 0);
        expect_at(680, S_TIMEOUT, 1);
        request(590);
        run_to(685);

        // Enable drop mid-frame, then re-enable clears sticky status
        iv_burst_count  = 8'd4;
        iv_fval_timeout = 26'd0;
        pulse_q.push_back(693);
        expect_at(754, S_BUSY, 1);
        expect_at(754, S_REMAIN, 3);
        expect_at(755, S_BUSY, 0);
        expect_at(755, S_REMAIN, 0);
        expect_at(755, S_TIMEOUT, 1);
        expect_at(755, S_MISSED, 15);
        expect_at(851, S_TIMEOUT, 1);
        expect_at(851, S_MISSED, 15);
        expect_at(852, S_TIMEOUT, 0);
        expect_at(852, S_MISSED, 0);
        request(690);
        run_to(753);
        i_acquisition_start = 1'b0;
        run_to(850);
        i_acquisition_start = 1'b1;

        // Reset during holdoff, then no spontaneous pulses
        iv_burst_count = 8'd2;
        pulse_q.push_back(863);
        expect_at(880, S_MISSED, 2);
        expect_at(941, S_BUSY, 1);
        expect_at(941, S_REMAIN, 1);
        for (int s = 0; s < 4; s++) expect_at(942, s, 0);
        request(860);
        request(873);
        request(875);
        run_to(941);
        reset_n = 1'b0;
        run_to(943);
        reset_n = 1'b1;
        run_to(970);
        done = 1'b1;
    end

endmodule
